demux_pack_n: RTL and testbench
===============================

Name: demux_pack_n

Overview:
Registered 1-to-N demultiplexer and packer, the write-side counterpart of the N-to-1 concatenated-bus mux. It accepts one WidthOfInputs-bit word per handshake and steers it into slot Select of an N-slot frame register. When every slot is filled, it presents the frame as one concatenated bus with a valid/ready handshake. The frame layout matches the mux input layout: slot k occupies bits [k*W +: W], so a downstream mux can read any slot back directly.

Parameters:
WidthOfInputs, 8, bits per slot/word (W), min 1
NumberOfInputs, 4, number of slots (N), min 2; need not be a power of two
SelW, derived as max(1, $clog2(NumberOfInputs)), width of the Select port (localparam)

Ports:
Clock  in  1  rising-edge clock, sole clock domain
Reset_n  in  1  synchronous reset, active-low
In  in  W  write data
InValid  in  1  write request
InReady  out  1  block can accept the write this cycle
Select  in  SelW  destination slot index
ConcatanatedOutputs  out  N*W  packed frame; slot k at [k*W +: W]
OutValid  out  1  frame complete and held stable
OutReady  in  1  consumer takes the frame
SlotFull  out  N  per-slot written flags for the current frame
WriteStrobe  out  N  one-hot, registered; pulses one cycle after an accepted write, on the written slot
SelError  out  1  sticky; set on an accepted write with Select >= N

Behaviour:
- Reset (Reset_n == 0 at a rising edge) clears the following to 0: ConcatanatedOutputs, SlotFull, WriteStrobe, OutValid, SelError. State goes to FILL.
- Reset wins over every other event in that cycle. A frame that is mid-fill or being drained is discarded.
- The block has two states, FILL and DRAIN.
- FILL state:
  - InReady = 1.
  - Accepted write = InValid & InReady.
  - On an accepted write with Select < N: slot Select <= In, SlotFull[Select] <= 1, and WriteStrobe is one-hot at Select on the next cycle.
  - Writing a slot that is already full overwrites its data. SlotFull is unchanged.
  - On an accepted write with Select >= N: no slot changes, WriteStrobe stays 0, and SelError <= 1.
  - The state goes to DRAIN on the edge where SlotFull becomes all-ones, including the cycle in which the last write lands. OutValid rises in the same cycle as the final slot update, so fill-to-valid latency is 1 cycle after the last write.
- DRAIN state:
  - OutValid = 1.
  - ConcatanatedOutputs and SlotFull are frozen while OutReady = 0.
  - InReady = OutReady, so a write can complete only in the same cycle as the drain.
  - On OutValid & OutReady: SlotFull is cleared and the state goes to FILL. If a write is accepted in the same cycle, that write lands in the new frame with SlotFull = one-hot(Select).
  - With N == 1 slot-to-go this can chain directly; the general rule is that a frame is complete only when all N flags are set.
  - Data bits of unwritten slots in a new frame keep stale values. The consumer must not rely on them before OutValid.
- WriteStrobe is 0 in every cycle that does not follow an accepted in-range write.
- SelError clears only on reset.
- Throughput: at most one write per cycle. Best case N+0 cycles per frame with back-to-back drain overlap.
- All outputs are registered, except InReady, which is combinational from state and OutReady.

Optional Feature:
- Macro: DEMUX_PACK_AUTOINC_EN.
- When defined:
  - Select is ignored.
  - An internal SelW-bit write pointer, reset to 0, supplies the slot index. It increments on each accepted write and wraps from N-1 to 0.
  - The pointer also resets to 0 on a drain handshake; a write accepted in the drain cycle uses slot 0 and the pointer becomes 1.
  - SelError is tied to 0.
- When undefined: the pointer logic is absent and Select is used as specified above.

Test Plan:
1. Reset, then writes to slots 0..3 of 0x11, 0x22, 0x33, 0x44 on consecutive cycles (OutReady = 0) -> ConcatanatedOutputs = 0x44332211, OutValid = 1 one cycle after the last write, InReady = 0, and WriteStrobe pulses 0001, 0010, 0100, 1000 in sequence.
2. From a full frame, hold OutReady = 0 for 5 cycles, then pulse it with InValid = 1, Select = 2, In = 0xAA -> the frame is stable for 5 cycles; after the drain, SlotFull = 0100, OutValid = 0, and slot 2 = 0xAA.
3. Write slot 1 = 0x55, then slot 1 = 0x66, then fill slots 0, 2, 3 -> slot 1 = 0x66, and OutValid rises only after the 4th distinct slot is written.
4. N = 3, Select = 3 with InValid -> SelError = 1 and stays high; SlotFull and the data are unchanged; WriteStrobe = 000.
5. Mid-fill (SlotFull = 0011), drive Reset_n = 0 for one cycle -> all outputs 0, state FILL; a subsequent 4-slot fill produces a correct frame.
6. With DEMUX_PACK_AUTOINC_EN defined, 9 writes of 1..9, draining each frame immediately -> frames 0x04030201 and 0x08070605, then SlotFull = 0001 holding 9.

Source files
------------

// File: rtl/demux_pack_n_if.sv
// demux_pack_n_if: bus between a word producer / frame consumer and demux_pack_n.
//   In, InValid, InReady, Select    : word write channel (Select = slot index)
//   ConcatanatedOutputs, OutValid,
//   OutReady                        : packed frame channel, slot k at [k*W +: W]
//   SlotFull, WriteStrobe, SelError : status
// Modports: slave = the packer, master = the side driving it.
interface demux_pack_n_if #(
    parameter int WidthOfInputs  = 8,
    parameter int NumberOfInputs = 4
);
    localparam int SelW = (NumberOfInputs > 1) ? $clog2(NumberOfInputs) : 1;

    logic [WidthOfInputs-1:0]                In;
    logic                                    InValid;
    logic                                    InReady;
    logic [SelW-1:0]                         Select;
    logic [NumberOfInputs*WidthOfInputs-1:0] ConcatanatedOutputs;
    logic                                    OutValid;
    logic                                    OutReady;
    logic [NumberOfInputs-1:0]               SlotFull;
    logic [NumberOfInputs-1:0]               WriteStrobe;
    logic                                    SelError;

    modport slave (
        input  In, InValid, Select, OutReady,
        output InReady, ConcatanatedOutputs, OutValid, SlotFull, WriteStrobe, SelError
    );

    modport master (
        output In, InValid, Select, OutReady,
        input  InReady, ConcatanatedOutputs, OutValid, SlotFull, WriteStrobe, SelError
    );
endinterface

// File: rtl/demux_pack_n.sv
// demux_pack_n: registered 1-to-N demultiplexer/packer. Each accepted word is
// steered into slot Select of an N-slot frame; once every slot has been
// written the frame is offered on ConcatanatedOutputs with OutValid/OutReady.
// Ports:
//   Clock   : rising-edge clock
//   Reset_n : synchronous active-low reset
//   bus     : demux_pack_n_if.slave (write channel, frame channel, status)
// Build option: DEMUX_PACK_AUTOINC_EN replaces Select with an internal
// wrapping write pointer and ties SelError low.
module demux_pack_n #(
    parameter int WidthOfInputs  = 8,
    parameter int NumberOfInputs = 4
) (
    input  logic           Clock,
    input  logic           Reset_n,
    demux_pack_n_if.slave  bus
);
    localparam int SelW = (NumberOfInputs > 1) ? $clog2(NumberOfInputs) : 1;
    localparam int FW   = NumberOfInputs * WidthOfInputs;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [FW-1:0]             frame_q, frame_d;
    logic [NumberOfInputs-1:0] full_q, full_d;
    logic [NumberOfInputs-1:0] strobe_q;
    logic [NumberOfInputs-1:0] hit;
    logic                      sel_err_q, sel_err_d;
    logic                      in_ready, drain, accept, wr_ok;
    logic [SelW-1:0]           idx;

`ifdef DEMUX_PACK_AUTOINC_EN
    logic [SelW-1:0] ptr_q;
    logic            unused_select;

    assign unused_select = ^bus.Select;

    // A write landing in the drain cycle starts the new frame at slot 0.
    assign idx = drain ? '0 : ptr_q;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else if (drain) begin
            ptr_q <= accept ? SelW'(1) : '0;
        end else if (accept) begin
            ptr_q <= (ptr_q == SelW'(NumberOfInputs - 1)) ? '0 : ptr_q + SelW'(1);
        end
    end
`else
    assign idx = bus.Select;
`endif

    always_comb begin
        in_ready = (state_q == FILL) || bus.OutReady;
        drain    = (state_q == DRAIN) && bus.OutReady;
        accept   = bus.InValid && in_ready;

        // One-hot decode; an out-of-range index matches no slot.
        hit = '0;
        for (int unsigned k = 0; k < NumberOfInputs; k++) begin
            if (accept && (idx == SelW'(k))) begin
                hit[k] = 1'b1;
            end
        end
        wr_ok = |hit;

        full_d  = (drain ? '0 : full_q) | hit;
        frame_d = frame_q;
        for (int unsigned k = 0; k < NumberOfInputs; k++) begin
            if (hit[k]) begin
                frame_d[k*WidthOfInputs +: WidthOfInputs] = bus.In;
            end
        end

`ifdef DEMUX_PACK_AUTOINC_EN
        sel_err_d = 1'b0;
`else
        sel_err_d = sel_err_q || (accept && !wr_ok);
`endif

        // Complete frame (including one finished by this cycle's write) means DRAIN.
        state_d = (&full_d) ? DRAIN : FILL;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= FILL;
            frame_q   <= '0;
            full_q    <= '0;
            strobe_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            full_q    <= full_d;
            strobe_q  <= hit;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.InReady             = in_ready;
    assign bus.ConcatanatedOutputs = frame_q;
    assign bus.OutValid            = (state_q == DRAIN);
    assign bus.SlotFull            = full_q;
    assign bus.WriteStrobe         = strobe_q;
    assign bus.SelError            = sel_err_q;
endmodule

// File: tb/tb_demux_pack_n.sv
// tb_demux_pack_n: directed bench for demux_pack_n. Instance a is N=4/W=8,
// instance b is N=3/W=8 (out-of-range Select). With DEMUX_PACK_AUTOINC_EN
// defined, the auto-increment sequence runs instead of the Select-based tests.
module tb_demux_pack_n;
    logic Clock;
    logic Reset_n;
    int   n_checks;
    int   n_fail;

    demux_pack_n_if #(.WidthOfInputs(8), .NumberOfInputs(4)) bus_a ();
    demux_pack_n_if #(.WidthOfInputs(8), .NumberOfInputs(3)) bus_b ();

    demux_pack_n #(.WidthOfInputs(8), .NumberOfInputs(4)) dut_a (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus_a)
    );

    demux_pack_n #(.WidthOfInputs(8), .NumberOfInputs(3)) dut_b (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr_a(input logic [1:0] sel, input logic [7:0] data);
        bus_a.Select  = sel;
        bus_a.In      = data;
        bus_a.InValid = 1'b1;
        tick();
        bus_a.InValid = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] sel, input logic [7:0] data);
        bus_b.Select  = sel;
        bus_b.In      = data;
        bus_b.InValid = 1'b1;
        tick();
        bus_b.InValid = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset_n  = 1'b1;
        bus_a.In = '0; bus_a.InValid = 1'b0; bus_a.Select = '0; bus_a.OutReady = 1'b0;
        bus_b.In = '0; bus_b.InValid = 1'b0; bus_b.Select = '0; bus_b.OutReady = 1'b0;
        #2;
        do_reset();

        check("rst_frame",   64'(bus_a.ConcatanatedOutputs), 64'h0);
        check("rst_full",    64'(bus_a.SlotFull),            64'h0);
        check("rst_strobe",  64'(bus_a.WriteStrobe),         64'h0);
        check("rst_valid",   64'(bus_a.OutValid),            64'h0);
        check("rst_selerr",  64'(bus_a.SelError),            64'h0);
        check("rst_inready", 64'(bus_a.InReady),             64'h1);

`ifdef DEMUX_PACK_AUTOINC_EN
        // Words 1..9 back to back, consumer always ready; Select is junk.
        bus_a.OutReady = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            bus_a.Select  = 2'd3;
            bus_a.In      = 8'(i);
            bus_a.InValid = 1'b1;
            tick();
            if (i == 4) begin
                check("ai_frame0", 64'(bus_a.ConcatanatedOutputs), 64'h04030201);
                check("ai_valid0", 64'(bus_a.OutValid),            64'h1);
            end
            if (i == 5) begin
                check("ai_full5",  64'(bus_a.SlotFull), 64'h1);
                check("ai_valid5", 64'(bus_a.OutValid), 64'h0);
            end
            if (i == 8) begin
                check("ai_frame1", 64'(bus_a.ConcatanatedOutputs), 64'h08070605);
                check("ai_valid1", 64'(bus_a.OutValid),            64'h1);
            end
        end
        bus_a.InValid = 1'b0;
        check("ai_full9",   64'(bus_a.SlotFull),            64'h1);
        check("ai_slot0",   64'(bus_a.ConcatanatedOutputs), 64'h08070609);
        check("ai_valid9",  64'(bus_a.OutValid),            64'h0);
        check("ai_strobe9", 64'(bus_a.WriteStrobe),         64'h1);
        check("ai_selerr",  64'(bus_a.SelError),            64'h0);
        wr_b(2'd3, 8'hFF);
        check("ai_b_selerr", 64'(bus_b.SelError), 64'h0);
        check("ai_b_full",   64'(bus_b.SlotFull), 64'h1);
`else
        // Test 1: fill slots 0..3, consumer stalled.
        for (int i = 0; i < 4; i++) begin
            wr_a(2'(i), 8'(8'h11 * (i + 1)));
            check($sformatf("t1_strobe%0d", i), 64'(bus_a.WriteStrobe), 64'(1 << i));
            check($sformatf("t1_valid%0d", i),  64'(bus_a.OutValid),    64'(i == 3));
        end
        check("t1_frame",   64'(bus_a.ConcatanatedOutputs), 64'h44332211);
        check("t1_full",    64'(bus_a.SlotFull),            64'hF);
        check("t1_inready", 64'(bus_a.InReady),             64'h0);

        // Test 2: hold 5 cycles, then drain with a write to slot 2 in the same cycle.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_frame",  64'(bus_a.ConcatanatedOutputs), 64'h44332211);
            check("t2_hold_valid",  64'(bus_a.OutValid),            64'h1);
            check("t2_hold_strobe", 64'(bus_a.WriteStrobe),         64'h0);
        end
        bus_a.OutReady = 1'b1;
        #1;
        check("t2_inready_drain", 64'(bus_a.InReady), 64'h1);
        wr_a(2'd2, 8'hAA);
        bus_a.OutReady = 1'b0;
        check("t2_full",   64'(bus_a.SlotFull),            64'h4);
        check("t2_valid",  64'(bus_a.OutValid),            64'h0);
        check("t2_frame",  64'(bus_a.ConcatanatedOutputs), 64'h44AA2211);
        check("t2_strobe", 64'(bus_a.WriteStrobe),         64'h4);

        // Test 3: overwrite slot 1, then complete the frame.
        wr_a(2'd1, 8'h55);
        check("t3_full_a", 64'(bus_a.SlotFull), 64'h6);
        wr_a(2'd1, 8'h66);
        check("t3_full_b", 64'(bus_a.SlotFull), 64'h6);
        wr_a(2'd0, 8'h01);
        check("t3_valid_c", 64'(bus_a.OutValid), 64'h0);
        wr_a(2'd2, 8'h02);
        check("t3_valid_d", 64'(bus_a.OutValid), 64'h0);
        wr_a(2'd3, 8'h03);
        check("t3_valid_e", 64'(bus_a.OutValid),            64'h1);
        check("t3_frame",   64'(bus_a.ConcatanatedOutputs), 64'h03026601);
        bus_a.OutReady = 1'b1;
        tick();
        bus_a.OutReady = 1'b0;
        check("t3_drain_valid",  64'(bus_a.OutValid),    64'h0);
        check("t3_drain_full",   64'(bus_a.SlotFull),    64'h0);
        check("t3_drain_strobe", 64'(bus_a.WriteStrobe), 64'h0);

        // Test 5: reset mid-fill, with a write pending that reset must beat.
        wr_a(2'd0, 8'hA0);
        wr_a(2'd1, 8'hA1);
        check("t5_mid_full", 64'(bus_a.SlotFull), 64'h3);
        bus_a.Select  = 2'd2;
        bus_a.In      = 8'hEE;
        bus_a.InValid = 1'b1;
        Reset_n       = 1'b0;
        tick();
        Reset_n       = 1'b1;
        bus_a.InValid = 1'b0;
        check("t5_rst_frame",  64'(bus_a.ConcatanatedOutputs), 64'h0);
        check("t5_rst_full",   64'(bus_a.SlotFull),            64'h0);
        check("t5_rst_strobe", 64'(bus_a.WriteStrobe),         64'h0);
        check("t5_rst_valid",  64'(bus_a.OutValid),            64'h0);
        for (int i = 0; i < 4; i++) begin
            wr_a(2'(i), 8'(8'hB0 + i));
        end
        check("t5_frame", 64'(bus_a.ConcatanatedOutputs), 64'hB3B2B1B0);
        check("t5_valid", 64'(bus_a.OutValid),            64'h1);

        // Test 4: N=3, Select=3 is out of range.
        wr_b(2'd0, 8'h5A);
        check("t4_full0", 64'(bus_b.SlotFull), 64'h1);
        wr_b(2'd3, 8'hFF);
        check("t4_selerr",  64'(bus_b.SelError),            64'h1);
        check("t4_full",    64'(bus_b.SlotFull),            64'h1);
        check("t4_frame",   64'(bus_b.ConcatanatedOutputs), 64'h00005A);
        check("t4_strobe",  64'(bus_b.WriteStrobe),         64'h0);
        wr_b(2'd1, 8'h11);
        check("t4_selerr_sticky", 64'(bus_b.SelError),    64'h1);
        check("t4_strobe1",       64'(bus_b.WriteStrobe), 64'h2);
        wr_b(2'd2, 8'h22);
        check("t4_valid",   64'(bus_b.OutValid),            64'h1);
        check("t4_frame3",  64'(bus_b.ConcatanatedOutputs), 64'h22115A);
        check("t4_inready", 64'(bus_b.InReady),             64'h0);
        bus_b.OutReady = 1'b1;
        tick();
        bus_b.OutReady = 1'b0;
        check("t4_drained",    64'(bus_b.OutValid), 64'h0);
        check("t4_selerr_end", 64'(bus_b.SelError), 64'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
